aes128_round_sequencer: RTL

Iterative AES-128 encryption controller.
- Accepts one plaintext/key pair over a valid/ready handshake.
- Performs the initial AddRoundKey, then sequences one cipher round per clock through the shared combinational round datapath (full round, or final round without MixColumns).
- Expands round keys on the fly and returns the ciphertext over a valid/ready handshake.
- Sits between the host interface and the round/final-round datapath.

---
 rtl/aes_pkg.sv | 64 ++++++
 rtl/aes128_key_step.sv | 28 ++
 rtl/aes128_round_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, S-box table and byte helpers for the round sequencer and key schedule.
package aes_pkg;

    typedef logic [3:0][3:0][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic state_t to_state(input logic [127:0] f);
        state_t s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[r][c] = f[127 - 8 * (4 * c + r) -: 8];
            end
        end
        return s;
    endfunction

    function automatic logic [127:0] to_flat(input state_t s);
        logic [127:0] f;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                f[127 - 8 * (4 * c + r) -: 8] = s[r][c];
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one and rcon.
module aes128_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] rk_next_o
);

    logic [31:0] w0_s, w1_s, w2_s, w3_s;
    logic [31:0] temp_s;
    logic [31:0] n0_s, n1_s, n2_s, n3_s;

    assign w0_s = rk_i[127:96];
    assign w1_s = rk_i[95:64];
    assign w2_s = rk_i[63:32];
    assign w3_s = rk_i[31:0];

    assign temp_s = sub_word({w3_s[23:0], w3_s[31:24]}) ^ {rcon_i, 24'h000000};

    assign n0_s = w0_s ^ temp_s;
    assign n1_s = w1_s ^ n0_s;
    assign n2_s = w2_s ^ n1_s;
    assign n3_s = w3_s ^ n2_s;

    assign rk_next_o = {n0_s, n1_s, n2_s, n3_s};

endmodule

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryption controller driving an external one-round-per-clock datapath.
// Build option: define AES_SEQ_ABORT_EN to make the abort input cancel a RUN/DONE operation.
module aes128_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned NR = 32'd10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_pt,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_ct,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    output logic         dp_final,
    input  logic [127:0] dp_result,
    input  logic         abort
);

    localparam logic [3:0] NR_C = 4'(NR);

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] ct_q, ct_d;
    logic [3:0]   round_cnt_q, round_cnt_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] rk_next_s;
    logic         last_round_s;
    logic         abort_req_s;

`ifdef AES_SEQ_ABORT_EN
    assign abort_req_s = abort;
`else
    logic unused_abort_s;
    assign unused_abort_s = abort;
    assign abort_req_s    = 1'b0;
`endif

    aes128_key_step u_key_step (
        .rk_i      (rk_q),
        .rcon_i    (rcon_q),
        .rk_next_o (rk_next_s)
    );

    assign last_round_s = (round_cnt_q == NR_C);

    // Next-state, round bookkeeping and datapath presentation.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        rk_d        = rk_q;
        ct_d        = ct_q;
        round_cnt_d = round_cnt_q;
        rcon_d      = rcon_q;
        dp_state    = state_q;
        dp_key      = rk_q;
        dp_final    = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = in_pt ^ in_key;
                    rk_d        = in_key;
                    round_cnt_d = 4'd1;
                    rcon_d      = 8'h01;
                    fsm_d       = RUN;
                end else begin
                    fsm_d = IDLE;
                end
            end
            RUN: begin
                dp_key   = rk_next_s;
                dp_final = last_round_s;
                if (abort_req_s) begin
                    fsm_d       = IDLE;
                    state_d     = 128'd0;
                    rk_d        = 128'd0;
                    round_cnt_d = 4'd0;
                end else begin
                    state_d = dp_result;
                    rk_d    = rk_next_s;
                    rcon_d  = xtime(rcon_q);
                    if (last_round_s) begin
                        fsm_d = DONE;
                        ct_d  = dp_result;
                    end else begin
                        round_cnt_d = round_cnt_q + 4'd1;
                    end
                end
            end
            DONE: begin
                if (abort_req_s) begin
                    fsm_d       = IDLE;
                    state_d     = 128'd0;
                    rk_d        = 128'd0;
                    round_cnt_d = 4'd0;
                end else if (out_ready) begin
                    fsm_d = IDLE;
                end else begin
                    fsm_d = DONE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= 128'd0;
            rk_q        <= 128'd0;
            ct_q        <= 128'd0;
            round_cnt_q <= 4'd0;
            rcon_q      <= 8'h01;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rk_q        <= rk_d;
            ct_q        <= ct_d;
            round_cnt_q <= round_cnt_d;
            rcon_q      <= rcon_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign out_ct    = ct_q;

endmodule
